esm_dwell_sequencer: RTL and testbench

Executes a dwell program: a linked list of up to NUM_INSTRUCTIONS instructions, each naming a dwell entry, a repeat count and a next-instruction link. It issues dwell requests by entry index to the downstream dwell executor and waits for each dwell to complete before issuing the next. It also applies the optional delayed start (timestamp compare) and the global loop counter. It sits inside the dwell controller, between the config message decoder and the dwell entry memory/executor.

---
 rtl/esm_dwell_sequencer.sv | 146 ++++++++++++++
 tb/tb_esm_dwell_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/esm_dwell_sequencer.sv
// esm_dwell_sequencer: walks a linked list of dwell instructions and issues
// one dwell request per repeat to the downstream executor.
//   clk_i / rst_ni              clock, asynchronous active-low reset
//   inst_wr_*_i                 instruction memory write port (ignored while active)
//   program_*_i                 header fields, latched on a program_start_i pulse
//   timestamp_i                 free-running time used for the delayed start
//   dwell_req_*                 request handshake towards the dwell executor
//   dwell_done_i                executor reports the current dwell finished
//   active_o / global_counter_o program status
module esm_dwell_sequencer #(
    parameter int NUM_INSTRUCTIONS  = 32,
    parameter int INST_INDEX_WIDTH  = 5,
    parameter int ENTRY_INDEX_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         inst_wr_valid_i,
    input  logic [INST_INDEX_WIDTH-1:0]  inst_wr_index_i,
    input  logic [31:0]                  inst_wr_data_i,
    input  logic                         program_start_i,
    input  logic                         program_enable_i,
    input  logic                         program_delayed_start_i,
    input  logic [31:0]                  program_global_counter_init_i,
    input  logic [63:0]                  program_delayed_start_time_i,
    input  logic [63:0]                  timestamp_i,
    output logic                         dwell_req_valid_o,
    input  logic                         dwell_req_ready_i,
    output logic [ENTRY_INDEX_WIDTH-1:0] dwell_req_entry_index_o,
    output logic [INST_INDEX_WIDTH-1:0]  dwell_req_inst_index_o,
    input  logic                         dwell_done_i,
    output logic                         active_o,
    output logic [31:0]                  global_counter_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_FETCH, S_DECODE, S_REQ, S_WAIT_DONE, S_ADVANCE
    } state_t;

    logic [31:0]                 mem [NUM_INSTRUCTIONS];
    state_t                      state_q;
    logic [INST_INDEX_WIDTH-1:0] pc_q;
    logic [31:0]                 inst_q;
    logic [7:0]                  rep_q;
    logic [31:0]                 gc_q;
    logic [63:0]                 start_time_q;
    logic                        req_valid_q;
    logic                        abort_q;
    logic                        unused;

    // Instruction fields: [0] valid, [1] gc_check, [2] gc_dec, [15:8] repeat,
    // [23:16] entry_index, [31:24] next_index.
    logic       inst_valid, inst_gc_check, inst_gc_dec;
    logic [7:0] inst_next;
    assign inst_valid    = inst_q[0];
    assign inst_gc_check = inst_q[1];
    assign inst_gc_dec   = inst_q[2];
    assign inst_next     = inst_q[31:24];
    assign unused        = ^inst_q[7:3];

    always_ff @(posedge clk_i) begin
        if (inst_wr_valid_i && state_q == S_IDLE)
            mem[inst_wr_index_i] <= inst_wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            rep_q        <= '0;
            gc_q         <= '0;
            start_time_q <= '0;
            req_valid_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (program_start_i && program_enable_i) begin
                        gc_q         <= program_global_counter_init_i;
                        start_time_q <= program_delayed_start_time_i;
                        pc_q         <= '0;
                        state_q      <= program_delayed_start_i ? S_WAIT_START : S_FETCH;
                    end
                end
                S_WAIT_START: begin
                    if (program_start_i)
                        state_q <= S_IDLE;
                    else if (timestamp_i >= start_time_q)
                        state_q <= S_FETCH;
                end
                S_FETCH: begin
                    inst_q  <= mem[pc_q];
                    state_q <= program_start_i ? S_IDLE : S_DECODE;
                end
                S_DECODE: begin
                    if (program_start_i || !inst_valid || (inst_gc_check && gc_q == '0)) begin
                        state_q <= S_IDLE;
                    end else begin
                        rep_q       <= inst_q[15:8];
                        req_valid_q <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A handshake in the same cycle as an abort has already been
                    // accepted, so the dwell is waited out before going idle.
                    if (dwell_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        abort_q     <= program_start_i;
                        state_q     <= S_WAIT_DONE;
                    end else if (program_start_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (program_start_i)
                        abort_q <= 1'b1;
                    if (dwell_done_i)
                        state_q <= (abort_q || program_start_i) ? S_IDLE : S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (program_start_i) begin
                        state_q <= S_IDLE;
                    end else if (rep_q != '0) begin
                        rep_q       <= rep_q - 8'd1;
                        req_valid_q <= 1'b1;
                        state_q     <= S_REQ;
                    end else begin
                        if (inst_gc_dec && gc_q != '0)
                            gc_q <= gc_q - 32'd1;
                        pc_q    <= inst_next[INST_INDEX_WIDTH-1:0];
                        state_q <= (32'(inst_next) >= NUM_INSTRUCTIONS) ? S_IDLE : S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dwell_req_valid_o       = req_valid_q;
    assign dwell_req_entry_index_o = inst_q[16 +: ENTRY_INDEX_WIDTH];
    assign dwell_req_inst_index_o  = pc_q;
    assign active_o                = state_q != S_IDLE;
    assign global_counter_o        = gc_q;
endmodule

// File: tb/tb_esm_dwell_sequencer.sv
// tb_esm_dwell_sequencer: directed self-checking bench for esm_dwell_sequencer.
module tb_esm_dwell_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_index = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0, enable = 1'b0, delayed = 1'b0;
    logic [31:0] gc_init = '0;
    logic [63:0] st_time = '0, ts = '0;
    logic        ready = 1'b0, done = 1'b0;
    logic        req_valid, active;
    logic [7:0]  req_entry;
    logic [4:0]  req_inst;
    logic [31:0] gc;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ts <= ts + 64'd1;

    esm_dwell_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .inst_wr_valid_i(wr_valid), .inst_wr_index_i(wr_index), .inst_wr_data_i(wr_data),
        .program_start_i(start), .program_enable_i(enable), .program_delayed_start_i(delayed),
        .program_global_counter_init_i(gc_init), .program_delayed_start_time_i(st_time),
        .timestamp_i(ts), .dwell_req_valid_o(req_valid), .dwell_req_ready_i(ready),
        .dwell_req_entry_index_o(req_entry), .dwell_req_inst_index_o(req_inst),
        .dwell_done_i(done), .active_o(active), .global_counter_o(gc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic v, input logic c, input logic d,
                                        input logic [7:0] rep, input logic [7:0] ent,
                                        input logic [7:0] nxt);
        return {nxt, ent, rep, 5'b0, d, c, v};
    endfunction

    task automatic wr(input int idx, input logic [31:0] d);
        wr_valid = 1'b1; wr_index = idx[4:0]; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic go(input logic dly, input logic [31:0] init, input logic [63:0] t);
        start = 1'b1; enable = 1'b1; delayed = dly; gc_init = init; st_time = t;
        @(negedge clk);
        start = 1'b0; enable = 1'b0; delayed = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 1000), 64'd1);
    endtask

    task automatic handshake(input string tag, input logic [7:0] ent, input logic [4:0] pc, input int hold);
        logic stable = 1'b1;
        wait_req(tag);
        check({tag, "_entry"}, 64'(req_entry), 64'(ent));
        check({tag, "_pc"}, 64'(req_inst), 64'(pc));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable &= req_valid && (req_entry == ent);
        end
        if (hold > 0) check({tag, "_stable"}, 64'(stable), 64'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_drop"}, 64'(req_valid), 64'd0);
    endtask

    task automatic dwell_done();
        repeat (2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [7:0] ent, input logic [4:0] pc);
        handshake(tag, ent, pc, 0);
        dwell_done();
    endtask

    task automatic idle_check(input string tag);
        int seen = 0;
        repeat (8) @(negedge clk);
        check({tag, "_active"}, 64'(active), 64'd0);
        repeat (10) begin
            @(negedge clk);
            seen += int'(req_valid);
        end
        check({tag, "_no_more_req"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0] t0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        check("rst_gc", 64'(gc), 64'd0);
        check("rst_entry", 64'(req_entry), 64'd0);
        check("rst_pc", 64'(req_inst), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start with enable low stays idle.
        start = 1'b1; enable = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("disabled_start", 64'(active), 64'd0);

        // Linear program: 10 entries in order.
        for (int i = 0; i < 10; i++) wr(i, enc(1, 0, 0, 8'd0, 8'(i), 8'(i + 1)));
        wr(10, 32'd0);
        wr(31, 32'd0);
        go(1'b0, 32'd0, 64'd0);
        check("lin_active", 64'(active), 64'd1);
        for (int i = 0; i < 10; i++) serve("lin", 8'(i), 5'(i));
        idle_check("lin");

        // Repeats with a stalled executor on the first request.
        wr(0, enc(1, 0, 0, 8'd3, 8'd5, 8'd31));
        go(1'b0, 32'd0, 64'd0);
        handshake("rep_hold", 8'd5, 5'd0, 20);
        dwell_done();
        for (int i = 1; i < 4; i++) serve("rep", 8'd5, 5'd0);
        idle_check("rep");

        // Global loop counter.
        wr(0, enc(1, 1, 1, 8'd0, 8'd7, 8'd0));
        go(1'b0, 32'd3, 64'd0);
        for (int k = 0; k < 3; k++) begin
            wait_req("gc");
            check("gc_value", 64'(gc), 64'(3 - k));
            serve("gc", 8'd7, 5'd0);
        end
        idle_check("gc");
        check("gc_final", 64'(gc), 64'd0);

        // Delayed start in the future.
        wr(0, enc(1, 0, 0, 8'd0, 8'd9, 8'd31));
        t0 = ts + 64'd500;
        go(1'b1, 32'd0, t0);
        wait_req("dly");
        check("dly_not_early", 64'(ts >= t0), 64'd1);
        check("dly_not_late", 64'(ts <= t0 + 64'd6), 64'd1);
        serve("dly", 8'd9, 5'd0);
        idle_check("dly");

        // Delayed start already in the past.
        start = 1'b1; enable = 1'b1; delayed = 1'b1; st_time = 64'd0;
        @(negedge clk);
        start = 1'b0; enable = 1'b0; delayed = 1'b0;
        n = 1;
        while (!req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("past_latency_le4", 64'(n <= 4), 64'd1);
        serve("past", 8'd9, 5'd0);
        idle_check("past");

        // Writes while active are ignored.
        wr(0, enc(1, 0, 0, 8'd1, 8'd12, 8'd31));
        go(1'b0, 32'd0, 64'd0);
        wait_req("wr_active");
        wr(0, enc(1, 0, 0, 8'd0, 8'd99, 8'd31));
        for (int i = 0; i < 2; i++) serve("wr_active", 8'd12, 5'd0);
        idle_check("wr_active");
        go(1'b0, 32'd0, 64'd0);
        for (int i = 0; i < 2; i++) serve("wr_rerun", 8'd12, 5'd0);
        idle_check("wr_rerun");

        // Abort while waiting for the dwell to finish.
        wr(0, enc(1, 0, 0, 8'd3, 8'd5, 8'd31));
        go(1'b0, 32'd0, 64'd0);
        handshake("abort", 8'd5, 5'd0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_waits_done", 64'(active), 64'd1);
        dwell_done();
        idle_check("abort");

        // Asynchronous reset while a request is pending.
        go(1'b0, 32'd5, 64'd0);
        wait_req("rst_req");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(req_valid), 64'd0);
        check("async_rst_active", 64'(active), 64'd0);
        check("async_rst_gc", 64'(gc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'(active), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
